// File: rtl/vector_pkg.sv
// Shared definitions for the vector ALU: vector length, lane op encodings and FSM states.
package vector_pkg;

  localparam int VLEN   = 5;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  localparam logic [IDX_W-1:0] IDX_LAST = 3'd4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHR  = 3'b110,
    OP_COPY = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  // Signed clamp value chosen by the sign of the first operand on overflow.
  function automatic logic [DATA_W-1:0] sat_clamp(input logic neg);
    return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational per-element ALU. Define VALU_SAT_EN for signed saturating add/sub.
module valu_lane
  import vector_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] elem,
  input  logic [DATA_W-1:0] scalar,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;
  logic [DATA_W-1:0] prod_s;
  logic [DATA_W-1:0] add_res_s;
  logic [DATA_W-1:0] sub_res_s;

  assign sum_s  = elem + scalar;
  assign diff_s = elem - scalar;
  assign prod_s = elem * scalar;

`ifdef VALU_SAT_EN
  logic add_ovf_s;
  logic sub_ovf_s;

  assign add_ovf_s = (elem[31] == scalar[31]) && (sum_s[31] != elem[31]);
  assign sub_ovf_s = (elem[31] != scalar[31]) && (diff_s[31] != elem[31]);
  assign add_res_s = add_ovf_s ? sat_clamp(elem[31]) : sum_s;
  assign sub_res_s = sub_ovf_s ? sat_clamp(elem[31]) : diff_s;
`else
  assign add_res_s = sum_s;
  assign sub_res_s = diff_s;
`endif

  // Lane operation select
  always_comb begin
    result = elem;
    case (op_e'(op))
      OP_ADD:  result = add_res_s;
      OP_SUB:  result = sub_res_s;
      OP_MUL:  result = prod_s;
      OP_AND:  result = elem & scalar;
      OP_OR:   result = elem | scalar;
      OP_XOR:  result = elem ^ scalar;
      OP_SHR:  result = elem >> scalar[4:0];
      OP_COPY: result = elem;
      default: result = elem;
    endcase
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Sequential 5-element vector ALU: one lane per cycle in EXEC, results written back in WB.
module vector_alu_seq
  import vector_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [3:0]        vd_in,
  input  logic [DATA_W-1:0] vr_0,
  input  logic [DATA_W-1:0] vr_1,
  input  logic [DATA_W-1:0] vr_2,
  input  logic [DATA_W-1:0] vr_3,
  input  logic [DATA_W-1:0] vr_4,
  input  logic [DATA_W-1:0] scalar,
  output logic              busy,
  output logic              done,
  output logic              vwe,
  output logic [3:0]        vd,
  output logic [DATA_W-1:0] wd_0,
  output logic [DATA_W-1:0] wd_1,
  output logic [DATA_W-1:0] wd_2,
  output logic [DATA_W-1:0] wd_3,
  output logic [DATA_W-1:0] wd_4
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [2:0]        op_r;
  logic [3:0]        vd_cap_r;
  logic [DATA_W-1:0] scalar_r;
  logic [DATA_W-1:0] vr_r  [VLEN];
  logic [DATA_W-1:0] res_r [VLEN];
  logic [DATA_W-1:0] wd_r  [VLEN];
  logic [3:0]        vd_r;
  logic [DATA_W-1:0] elem_s;
  logic [DATA_W-1:0] lane_res_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_nxt_s = ST_EXEC; else state_nxt_s = ST_IDLE;
      ST_EXEC: if (idx_r == IDX_LAST) state_nxt_s = ST_WB; else state_nxt_s = ST_EXEC;
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    vwe  = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_EXEC: busy = 1'b1;
      ST_WB: begin
        busy = 1'b1;
        done = 1'b1;
        vwe  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Element select for the current lane
  always_comb begin
    elem_s = vr_r[0];
    case (idx_r)
      3'd0:    elem_s = vr_r[0];
      3'd1:    elem_s = vr_r[1];
      3'd2:    elem_s = vr_r[2];
      3'd3:    elem_s = vr_r[3];
      3'd4:    elem_s = vr_r[4];
      default: elem_s = vr_r[0];
    endcase
  end

  valu_lane u_lane (
    .op     (op_r),
    .elem   (elem_s),
    .scalar (scalar_r),
    .result (lane_res_s)
  );

  // Operand capture, per-lane results and write-back registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r    <= 3'd0;
      op_r     <= 3'd0;
      vd_cap_r <= 4'd0;
      scalar_r <= 32'd0;
      vd_r     <= 4'd0;
      for (int i = 0; i < VLEN; i++) begin
        vr_r[i]  <= 32'd0;
        res_r[i] <= 32'd0;
        wd_r[i]  <= 32'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r     <= op;
            vd_cap_r <= vd_in;
            scalar_r <= scalar;
            vr_r[0]  <= vr_0;
            vr_r[1]  <= vr_1;
            vr_r[2]  <= vr_2;
            vr_r[3]  <= vr_3;
            vr_r[4]  <= vr_4;
            idx_r    <= 3'd0;
          end
        end
        ST_EXEC: begin
          for (int i = 0; i < VLEN; i++) begin
            if (idx_r == IDX_W'(i)) res_r[i] <= lane_res_s;
          end
          if (idx_r == IDX_LAST) begin
            // Output copy is taken here so wd_* stay stable outside WB.
            idx_r <= 3'd0;
            vd_r  <= vd_cap_r;
            for (int i = 0; i < VLEN - 1; i++) wd_r[i] <= res_r[i];
            wd_r[VLEN-1] <= lane_res_s;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        ST_WB:   idx_r <= 3'd0;
        default: idx_r <= 3'd0;
      endcase
    end
  end

  assign vd   = vd_r;
  assign wd_0 = wd_r[0];
  assign wd_1 = wd_r[1];
  assign wd_2 = wd_r[2];
  assign wd_3 = wd_r[3];
  assign wd_4 = wd_r[4];

endmodule

// File: tb/tb_vector_alu_seq.sv
// Scoreboard bench for vector_alu_seq: directed vectors, expected write-backs queued at issue.
module tb_vector_alu_seq;

  typedef struct packed {
    logic [3:0]       vd;
    logic [4:0][31:0] wd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [3:0]  vd_in;
  logic [31:0] vr_0, vr_1, vr_2, vr_3, vr_4, scalar;
  logic        busy, done, vwe;
  logic [3:0]  vd;
  logic [31:0] wd_0, wd_1, wd_2, wd_3, wd_4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vector_alu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .vd_in(vd_in),
    .vr_0(vr_0), .vr_1(vr_1), .vr_2(vr_2), .vr_3(vr_3), .vr_4(vr_4),
    .scalar(scalar), .busy(busy), .done(done), .vwe(vwe), .vd(vd),
    .wd_0(wd_0), .wd_1(wd_1), .wd_2(wd_2), .wd_3(wd_3), .wd_4(wd_4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0][31:0] v5(input logic [31:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [3:0] d,
                       input logic [4:0][31:0] v, input logic [31:0] s);
    op = o; vd_in = d; scalar = s;
    vr_0 = v[0]; vr_1 = v[1]; vr_2 = v[2]; vr_3 = v[3]; vr_4 = v[4];
  endtask

  // Issue one op in cycle 0 and check busy/done over cycles 1..7
  task automatic run_op(input logic [2:0] o, input logic [3:0] d,
                        input logic [4:0][31:0] v, input logic [31:0] s,
                        input logic [4:0][31:0] exp_wd);
    exp_t e;
    drive(o, d, v, s);
    start = 1'b1;
    e.vd = d; e.wd = exp_wd;
    sb.push_back(e);
    tick();
    start = 1'b0;
    drive(3'd0, 4'd0, v5(32'd0, 32'd0, 32'd0, 32'd0, 32'd0), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("done_c%0d", c), {31'd0, done}, (c == 6) ? 32'd1 : 32'd0);
      tick();
    end
    chk("busy_c7", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor: each write-back pops one expected entry
  always @(negedge clk) begin
    if (vwe === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vwe: got vwe=1 vd=%0d expected no write at %0t", vd, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_vd", {28'd0, vd}, {28'd0, e.vd});
        chk("wb_done", {31'd0, done}, 32'd1);
        chk("wb_wd0", wd_0, e.wd[0]);
        chk("wb_wd1", wd_1, e.wd[1]);
        chk("wb_wd2", wd_2, e.wd[2]);
        chk("wb_wd3", wd_3, e.wd[3]);
        chk("wb_wd4", wd_4, e.wd[4]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] sat_add, sat_sub;
`ifdef VALU_SAT_EN
    sat_add = 32'h7FFF_FFFF;
    sat_sub = 32'h8000_0000;
`else
    sat_add = 32'h8000_0010;
    sat_sub = 32'h7FFF_FFFB;
`endif
    reset = 1'b1; start = 1'b0;
    drive(3'd0, 4'd0, v5(32'd0, 32'd0, 32'd0, 32'd0, 32'd0), 32'd0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vwe", {31'd0, vwe}, 32'd0);
    chk("rst_vd", {28'd0, vd}, 32'd0);
    chk("rst_wd0", wd_0, 32'd0);

    run_op(3'b000, 4'd3, v5(1, 2, 3, 4, 5), 32'd10, v5(11, 12, 13, 14, 15));
    run_op(3'b010, 4'd4, v5(32'h10000, 2, 3, 4, 5), 32'h10000,
           v5(0, 32'h20000, 32'h30000, 32'h40000, 32'h50000));
    run_op(3'b000, 4'd5, v5(32'h7FFF_FFF0, 1, 2, 3, 4), 32'h20,
           v5(sat_add, 32'h21, 32'h22, 32'h23, 32'h24));
    run_op(3'b001, 4'd6, v5(10, 5, 0, 32'h8000_0000, 100), 32'd5,
           v5(5, 0, 32'hFFFF_FFFB, sat_sub, 95));
    run_op(3'b011, 4'd7, v5(32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 32'h1234_5678),
           32'h0FF0_0FF0, v5(32'h0F00_0F00, 32'h0F00_0F00, 32'h0FF0_0FF0, 0, 32'h0230_0670));
    run_op(3'b100, 4'd8, v5(32'hF0, 32'h0F, 0, 1, 32'h8000_0000), 32'h100,
           v5(32'h1F0, 32'h10F, 32'h100, 32'h101, 32'h8000_0100));
    run_op(3'b101, 4'd10, v5(32'hFFFF_FFFF, 32'hAAAA_AAAA, 0, 32'h5555, 32'h1234),
           32'hFFFF_0000, v5(32'h0000_FFFF, 32'h5555_AAAA, 32'hFFFF_0000, 32'hFFFF_5555, 32'hFFFF_1234));
    run_op(3'b110, 4'd11, v5(32'h8000_0000, 32'hF0, 32'hFFFF_FFFF, 32'h1234_5678, 8), 32'h24,
           v5(32'h0800_0000, 32'h0F, 32'h0FFF_FFFF, 32'h0123_4567, 0));

    // Start held through busy with other operands: ignored until cycle 7
    drive(3'b000, 4'd1, v5(1, 2, 3, 4, 5), 32'd1);
    start = 1'b1;
    e.vd = 4'd1; e.wd = v5(2, 3, 4, 5, 6);
    sb.push_back(e);
    tick();
    drive(3'b111, 4'd9, v5(7, 8, 9, 10, 11), 32'd99);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("ign_busy_c%0d", c), {31'd0, busy}, 32'd1);
      tick();
    end
    chk("ign_busy_c7", {31'd0, busy}, 32'd0);
    e.vd = 4'd9; e.wd = v5(7, 8, 9, 10, 11);
    sb.push_back(e);
    tick();
    start = 1'b0;
    chk("ign_accept_c8", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 7; c++) tick();

    // Reset in cycle 3 aborts the op
    drive(3'b000, 4'd2, v5(1, 1, 1, 1, 1), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_vd", {28'd0, vd}, 32'd0);
    chk("abort_wd0", wd_0, 32'd0);
    chk("abort_wd1", wd_1, 32'd0);
    chk("abort_wd2", wd_2, 32'd0);
    chk("abort_wd3", wd_3, 32'd0);
    chk("abort_wd4", wd_4, 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk("abort_no_vwe", {31'd0, vwe}, 32'd0);
      tick();
    end

    // Reset has priority over start
    drive(3'b000, 4'd12, v5(1, 2, 3, 4, 5), 32'd1);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy0", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_start_busy1", {31'd0, busy}, 32'd0);
    tick(); tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
